// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int REG_AW_D = 5;
  localparam int X0_IDX   = 0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_md_scoreboard.sv
// Busy/countdown tracker for the single multi-cycle mul/div unit.
// md_done pulses in the last busy cycle; a start in that cycle reissues.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_D,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_md_start,
  input  logic              ex_flush,
  input  logic [REG_AW-1:0] ex_rd_idx,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_rd_idx
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              start_ok;

  assign start_ok  = ex_md_start & ~ex_flush;
  assign md_busy   = (state_q == BUSY);
  assign md_rd_idx = rd_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    md_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LAT - 1);
          rd_d    = ex_rd_idx;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          md_done = 1'b1;
          if (start_ok) begin
            cnt_d = CNT_W'(MD_LAT - 1);
            rd_d  = ex_rd_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The md stall keeps a second op out of EX until the done cycle.
  a_no_overlap: assert property (@(posedge clk) disable iff (!rstn)
    !(start_ok && md_busy && !md_done));

endmodule

// File: rtl/hazard_ctrl.sv
// EX operand forwarding, load-use and mul/div stall control.
// Optional stall counters enabled by defining HAZARD_STATS_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_D,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_idx,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_md_op,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_idx,
  input  logic [REG_AW-1:0]         ex_rd_idx,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_md_start,
  input  logic                      ex_flush,
  input  logic [REG_AW-1:0]         mem_rd_idx,
  input  logic                      mem_reg_write,
  input  logic [REG_AW-1:0]         wb_rd_idx,
  input  logic                      wb_reg_write,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_pc,
  output logic                      stall_ifid,
  output logic                      bubble_idex,
  output logic                      md_busy,
  output logic                      md_done,
  output logic [REG_AW-1:0]         md_rd_idx
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               ld_stall_cnt,
  output logic [31:0]               md_stall_cnt
`endif
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(X0_IDX);

  logic ld_hz, md_hz, raw_md, stall;
  logic [REG_AW-1:0] ex_rs, id_rs;

  md_scoreboard #(
    .REG_AW(REG_AW),
    .MD_LAT(MD_LAT),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .ex_md_start(ex_md_start),
    .ex_flush   (ex_flush),
    .ex_rd_idx  (ex_rd_idx),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_rd_idx  (md_rd_idx)
  );

  always_comb begin
    fwd_sel = '0;
    ex_rs   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_rs = ex_rs_idx[i*REG_AW +: REG_AW];
      fwd_sel[2*i +: 2] = FWD_RF;
      if (ex_rs != X0) begin
        if (mem_reg_write && mem_rd_idx == ex_rs)
          fwd_sel[2*i +: 2] = FWD_MEM;
        else if (wb_reg_write && wb_rd_idx == ex_rs)
          fwd_sel[2*i +: 2] = FWD_WB;
      end
    end
  end

  always_comb begin
    ld_hz  = 1'b0;
    raw_md = 1'b0;
    id_rs  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_rs = id_rs_idx[i*REG_AW +: REG_AW];
      if (id_rs_used[i] && id_rs == ex_rd_idx)
        ld_hz = 1'b1;
      if (id_rs_used[i] && id_rs == md_rd_idx)
        raw_md = 1'b1;
    end
    ld_hz  = ld_hz & ex_mem_read & ex_reg_write &
             ~ex_flush & (ex_rd_idx != X0);
    raw_md = raw_md & (md_rd_idx != X0);
  end

  // Released in the md_done cycle so the dependent op meets the result in WB.
  assign md_hz       = md_busy & ~md_done & (id_md_op | raw_md);
  assign stall       = ld_hz | md_hz;
  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idex = stall;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_stall_cnt <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (md_hz) begin
        if (md_stall_cnt != '1)
          md_stall_cnt <= md_stall_cnt + 32'd1;
      end else if (ld_hz) begin
        if (ld_stall_cnt != '1)
          ld_stall_cnt <= ld_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
